// File: rtl/sync_bus_endpoint.sv
// Clocked bus endpoint: req/ack handshake, programmable wait states,
// half-open address window decode and an optional read-only mode.
module sync_bus_endpoint #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int BASE_ADDR   = 0,
  parameter int RANGE       = 16,
  parameter int WAIT_STATES = 1,
  parameter int READ_ONLY   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  r_wn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  busy
);

  localparam int IDX_W = (RANGE > 1) ? $clog2(RANGE) : 1;

  // One extra bit so BASE_ADDR+RANGE never wraps at the top of the map.
  localparam logic [ADDR_WIDTH:0] LO = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] HI = (ADDR_WIDTH+1)'(BASE_ADDR + RANGE);
  localparam logic [7:0] WAIT_INIT   = 8'(WAIT_STATES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]            state;
  logic [7:0]            cnt;
  logic                  rd_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [RANGE];

  logic             hit;
  logic [IDX_W-1:0] idx;

  assign hit = req && ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);
  assign idx = IDX_W'({1'b0, addr} - LO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rd_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      // NOTE: storage is a register file that must read back as zero after
      // reset, so it is cleared here rather than left to power-up contents.
      for (int i = 0; i < RANGE; i++) mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hit) begin
            rd_q    <= r_wn;
            idx_q   <= idx;
            wdata_q <= wdata;
            if (WAIT_STATES == 0) begin
              state <= S_ACK;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_ACK;
          else           cnt   <= cnt - 8'd1;
        end
        S_ACK: begin
          state <= S_IDLE;
          if (!rd_q && (READ_ONLY == 0)) mem[idx_q] <= wdata_q;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from state, so reset silences them on the next edge.
  assign ack   = (state == S_ACK);
  assign busy  = (state != S_IDLE);
  assign rdata = (ack && rd_q) ? mem[idx_q] : '0;
  assign err   = ack && !rd_q && (READ_ONLY != 0);

endmodule

// File: doc/sync_bus_endpoint.md
Name: sync_bus_endpoint

Overview:
- Clocked successor to the combinational native-parallel-bus endpoint.
- Adds a req/ack handshake, programmable wait states, a half-open address decode, an optional read-only mode with error signalling, and synchronous reset of storage.
- Several instances share one master bus. Only the instance whose window contains the address responds; all other instances stay silent.

Parameters:
- ADDR_WIDTH, 8, bus address width.
- DATA_WIDTH, 8, data width.
- BASE_ADDR, 0, first address of the window.
- RANGE, 16, number of locations. Window is [BASE_ADDR, BASE_ADDR+RANGE-1]. RANGE >= 1; need not be a power of 2.
- WAIT_STATES, 1, extra cycles inserted before ack (0..255).
- READ_ONLY, 0, when 1, writes are acked with err and do not modify storage.

Ports:
- clk  in  1  bus clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  master request; addr/r_wn/wdata are valid while high.
- r_wn  in  1  1 = read, 0 = write.
- addr  in  ADDR_WIDTH  bus address.
- wdata  in  DATA_WIDTH  write data.
- ack  out  1  one-cycle completion pulse from this endpoint.
- rdata  out  DATA_WIDTH  read data; valid only while ack=1, otherwise 0.
- err  out  1  high with ack for a write to a READ_ONLY endpoint, otherwise 0.
- busy  out  1  high from acceptance until the ack cycle inclusive.

Behaviour:
- Decode: hit = req && (addr >= BASE_ADDR) && (addr < BASE_ADDR+RANGE).
  - Compare at ADDR_WIDTH+1 bits so BASE_ADDR+RANGE cannot overflow.
  - Local index = addr - BASE_ADDR, width max(1, $clog2(RANGE)).
- Storage: RANGE x DATA_WIDTH registers, all cleared to 0 on rst.
- Reset values: ack=0, rdata=0, err=0, busy=0, state=IDLE, wait counter=0.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on hit, latch r_wn, index and wdata.
    - Go to WAIT with counter = WAIT_STATES-1 if WAIT_STATES>0.
    - Go directly to ACK if WAIT_STATES=0.
    - A req with no hit leaves the FSM in IDLE with no output activity.
  - WAIT: decrement the counter each cycle; at 0, go to ACK. Bus inputs are ignored while in WAIT.
  - ACK: assert ack=1 for exactly one cycle, then return to IDLE.
    - Read: rdata = mem[latched index], from the registered value in this same cycle.
    - Write with READ_ONLY=0: mem[index] <= latched wdata on the edge that ends the ACK cycle.
    - Write with READ_ONLY=1: err=1, storage unchanged.
- Latency: with req first sampled high and hitting at edge N, ack is high in the cycle after edge N+WAIT_STATES, i.e. WAIT_STATES+1 cycles after acceptance.
- Handshake rules:
  - The master holds req until it samples ack, then drops it on that same edge.
  - A req still high in the IDLE cycle after ACK is a new transaction; back-to-back transfers are allowed.
- Input changes after acceptance have no effect because the transaction uses latched values.
- rst mid-transaction: on the next edge return to IDLE and drop busy/ack. No pending write is committed. Storage is cleared.
- rst has priority over every other event in the same cycle.
- At most one endpoint may hit any address. Overlapping windows are a system configuration error, and this block does not detect them.

Test Plan:
- BASE_ADDR=16, RANGE=16, WAIT_STATES=2. Write 0xA5 to addr 0x13 -> busy high for 3 cycles, ack exactly in the 3rd cycle after acceptance, err=0. Then read 0x13 -> ack after 3 cycles with rdata=0xA5; rdata=0 in every other cycle.
- Boundaries, same config:
  - addr 0x10 and 0x1F -> ack.
  - addr 0x0F and 0x20, req held 10 cycles -> ack=0 and busy=0 throughout.
  - Write to 0x20 -> location 0 is not modified.
- WAIT_STATES=0, back-to-back: req held high, writing 0x11 to 0x10 then 0x22 to 0x11 -> ack every second cycle. Subsequent reads return 0x11 and 0x22.
- Input change: change addr/wdata during WAIT -> the value originally latched is written to the originally latched location.
- Reset mid-op: rst asserted during WAIT of a write of 0x55 to 0x14 -> no ack; a later read of 0x14 returns 0x00; after reset all outputs are 0 on the next cycle.
- READ_ONLY=1: write 0x77 to 0x12 -> ack with err=1. Read 0x12 -> rdata=0x00, err=0.
